// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter that shares one J1-style I/O slave bus between NM masters.
// Bus strobes and the read-data return are registered; one transfer per clock.
module io_bus_arbiter #(
   parameter int NM = 2,
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NM-1:0]          m_req,
   input  logic [NM-1:0]          m_we,
   input  logic [NM-1:0][AW-1:0]  m_addr,
   input  logic [NM-1:0][DW-1:0]  m_wdata,
   output logic [NM-1:0]          m_gnt,
   output logic [NM-1:0]          m_rvalid,
   output logic [DW-1:0]          m_rdata,
   output logic                   io_rd,
   output logic                   io_wr,
   output logic [AW-1:0]          io_addr,
   output logic [DW-1:0]          io_dout,
   input  logic [DW-1:0]          io_din
);

   localparam int PW = (NM > 1) ? $clog2(NM) : 1;

   logic [PW-1:0] ptr_q, ptr_d;
   logic [PW-1:0] rdId_q;
   logic [PW-1:0] sel;
   logic          found;
   logic [NM-1:0] eligible;
   logic [NM-1:0] gnt_q, rvalid_q;
   logic [DW-1:0] rdata_q, dout_q;
   logic [AW-1:0] addr_q;
   logic          rd_q, wr_q;

   // The master granted last edge is still holding m_req while it sees m_gnt,
   // so it is masked for one cycle to avoid issuing a duplicate transfer.
   assign eligible = m_req & ~gnt_q;

   always_comb begin
      int idx;
      idx   = 0;
      found = 1'b0;
      sel   = '0;
      for (int i = 0; i < NM; i++) begin
         idx = (int'(ptr_q) + i) % NM;
         if (!found && eligible[idx]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
      ptr_d = PW'((int'(sel) + 1) % NM);
   end

   // Stage A issues the bus strobe; stage B captures read data and returns it
   // to the master whose id travelled with the read.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q    <= '0;
         rdId_q   <= '0;
         gnt_q    <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
         addr_q   <= '0;
         dout_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
      end else begin
         if (found) begin
            addr_q <= m_addr[sel];
            dout_q <= m_wdata[sel];
            wr_q   <= m_we[sel];
            rd_q   <= ~m_we[sel];
            gnt_q  <= NM'(1) << sel;
            ptr_q  <= ptr_d;
            rdId_q <= sel;
         end else begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            gnt_q <= '0;
         end
         if (rd_q) begin
            rdata_q  <= io_din;
            rvalid_q <= NM'(1) << rdId_q;
         end else begin
            rvalid_q <= '0;
         end
      end
   end

   assign m_gnt    = gnt_q;
   assign m_rvalid = rvalid_q;
   assign m_rdata  = rdata_q;
   assign io_rd    = rd_q;
   assign io_wr    = wr_q;
   assign io_addr  = addr_q;
   assign io_dout  = dout_q;

endmodule

// File: doc/io_bus_arbiter.md
Name: io_bus_arbiter

Overview:
- Shares one J1-style I/O slave bus (board_io, USB core registers, etc.) between NM requesters, e.g. the J1 CPU and a USB debug/command master.
- Round-robin arbitration with registered bus strobes and a registered read-data return.
- At most one single-cycle I/O transaction per clock; back-to-back transfers are supported.
- Slave side drives io.rd/io.wr/io.addr/io.dout and samples io.din.
  - io.din is the OR of all slaves' read data.
  - Each slave returns 0 when not addressed.

Parameters:
- NM, 2, number of requesters (2..8).
- AW, 16, I/O address width.
- DW, 16, data width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- m_req  input  NM  per-master request; held high until granted.
- m_we  input  NM  per-master direction: 1 = write, 0 = read; stable while m_req is high.
- m_addr  input  NM x AW  per-master address; stable while m_req is high.
- m_wdata  input  NM x DW  per-master write data; stable while m_req is high.
- m_gnt  output  NM  one-hot, single-cycle grant acknowledge.
- m_rvalid  output  NM  one-hot, single-cycle read-data-valid.
- m_rdata  output  DW  read data, shared by all masters; qualified by m_rvalid.
- io_rd  output  1  slave read strobe.
- io_wr  output  1  slave write strobe.
- io_addr  output  AW  slave address.
- io_dout  output  DW  slave write data.
- io_din  input  DW  slave read data (combinational from slaves, OR bus).

Behaviour:
- Clocking and reset
  - Clocks on clk; reset is synchronous, active-high.
  - Reset values: m_gnt = 0, m_rvalid = 0, m_rdata = 0, io_rd = 0, io_wr = 0, io_addr = 0, io_dout = 0.
  - Round-robin pointer resets to 0, so master 0 has highest priority first.
- Stage A, arbitration (edge T)
  - If any m_req is high, select the first requesting index at or after ptr, wrapping modulo NM.
  - At the edge, register the selected master's addr/wdata into io_addr/io_dout.
  - Set io_wr = m_we[sel] and io_rd = ~m_we[sel].
  - Set m_gnt[sel] = 1 for the following cycle; update ptr to (sel+1) mod NM.
  - If no request, io_rd = io_wr = 0; io_addr/io_dout hold their previous value.
- Stage B, bus cycle (cycle T+1)
  - Exactly one of io_rd/io_wr is high, for exactly one cycle.
  - The master samples m_gnt in this cycle and may drop m_req, or present its next request, in the same cycle.
  - For a read, io_din is captured at edge T+1 into m_rdata.
  - The id of the read's master is pipelined alongside the transaction.
- Stage C, read return (cycle T+2)
  - m_rvalid[id] = 1 for one cycle. m_rdata holds until the next read completes.
  - No m_rvalid is generated for writes.
- Latency
  - Request to bus strobe: 1 cycle.
  - Request to read data: 2 cycles.
  - Throughput: one transfer per cycle.
- Re-request rule
  - A request that is still high in the cycle m_gnt is asserted is not re-arbitrated in that cycle.
  - The arbiter masks the currently granted index for one cycle, so a slow master does not issue a duplicate transfer.
  - It is treated as a new request from the next edge onward.
- Simultaneous requests
  - Round-robin order is strict.
  - With all NM masters requesting continuously, each is granted once every NM transfers. No starvation.
- Single requester
  - The same master holding m_req continuously is granted every second cycle, because of the mask cycle.
  - An alternating pattern with another requester fills the gaps.
- Reset mid-operation
  - Reset cancels any pending strobe and read return; nothing is delivered after reset.
  - ptr returns to 0.
  - Masters must discard outstanding reads.
- Input sanity
  - m_gnt, m_rvalid, io_rd and io_wr are never asserted together for the same master in illegal combinations.
  - io_rd & io_wr is never 1.
  - m_gnt and m_rvalid are each at most one-hot.

Test Plan:
1. Reset. Hold reset 3 cycles with m_req = 2'b11 → all outputs 0; after release, master 0 is granted first; io_wr/io_rd follow 1 cycle after the first sampled request.
2. Single write. M1 writes addr 0x0004, data 0x00A5 → io_wr = 1 with io_addr = 0x0004, io_dout = 0x00A5 for exactly 1 cycle; m_gnt = 2'b10 in that cycle; no m_rvalid.
3. Single read. M0 reads addr 0x0001 while the slave drives io_din = 0x000B → io_rd = 1 one cycle after the request; m_rvalid = 2'b01 with m_rdata = 0x000B one cycle later.
4. Contention. Both masters request continuously for 8 transfers → grants alternate 0,1,0,1,…; io strobe high every cycle; the 4 grants each are ordered correctly.
5. Back-to-back reads. M0 and M1 read different addresses returning 0x1111 and 0x2222 → m_rvalid 01 then 10 on consecutive cycles, with the matching m_rdata each time.
6. Reset mid-read. Assert reset in the cycle io_rd = 1 → no m_rvalid afterwards; m_rdata = 0; the next arbitration starts at master 0.
